// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding control for the pipelined MIPS core.
// A shift-register scoreboard of in-flight writes drives stalls, flushes and operand forwarding.
module hazard_scoreboard #(
    parameter int AW       = 5,
    parameter int STAGES   = 3,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int SW       = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic          d_rs_used,
    input  logic          d_rt_used,
    input  logic [TW-1:0] d_rs_tuse,
    input  logic [TW-1:0] d_rt_tuse,
    input  logic [AW-1:0] d_wb,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_cp0wr,
    input  logic          d_eret,
    input  logic          d_md_start,
    input  logic          d_md_op,
    input  logic          d_md_use,
    input  logic          int_req,
    output logic          stall,
    output logic          stall_eret,
    output logic          md_busy,
    output logic [SW-1:0] fwd_d_rs,
    output logic [SW-1:0] fwd_d_rt,
    output logic [SW-1:0] fwd_e_rs,
    output logic [SW-1:0] fwd_e_rt,
    output logic [SW-1:0] fwd_m_rt,
    output logic          flush_d,
    output logic          flush_e,
    output logic          flush_mw
);
    localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic          slot_valid [1:STAGES];
    logic [AW-1:0] slot_wb    [1:STAGES];
    logic [AW-1:0] slot_rs    [1:STAGES];
    logic [AW-1:0] slot_rt    [1:STAGES];
    logic [TW-1:0] slot_tnew  [1:STAGES];
    logic          slot_cp0wr [1:STAGES];
    logic [CW-1:0] md_cnt;

    logic [STAGES:1] slot_live;
    logic [STAGES:1] slot_cp0_pend;

    logic [SW-1:0] d_rs_idx, d_rt_idx, e_rs_idx, e_rt_idx, m_rt_idx;
    logic [TW-1:0] d_rs_tnew, d_rt_tnew, e_rs_tnew, e_rt_tnew, m_rt_tnew;
    logic          rs_block, rt_block, md_block, accept;

    // Scoreboard slots: slot 1 takes the accepted D instruction (or a bubble),
    // later slots shift the older entry along while its tnew counts down to 0.
    generate
        for (genvar gi = 1; gi <= STAGES; gi++) begin : g_slot
            assign slot_live[gi]     = slot_valid[gi] && (slot_wb[gi] != '0);
            assign slot_cp0_pend[gi] = slot_valid[gi] && slot_cp0wr[gi];

            if (gi == 1) begin : g_head
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        slot_valid[gi] <= 1'b0;
                        slot_wb[gi]    <= '0;
                        slot_rs[gi]    <= '0;
                        slot_rt[gi]    <= '0;
                        slot_tnew[gi]  <= '0;
                        slot_cp0wr[gi] <= 1'b0;
                    end else if (accept) begin
                        slot_valid[gi] <= 1'b1;
                        slot_wb[gi]    <= d_wb;
                        slot_rs[gi]    <= d_rs;
                        slot_rt[gi]    <= d_rt;
                        slot_tnew[gi]  <= d_tnew;
                        slot_cp0wr[gi] <= d_cp0wr;
                    end else begin
                        slot_valid[gi] <= 1'b0;
                        slot_wb[gi]    <= '0;
                        slot_rs[gi]    <= '0;
                        slot_rt[gi]    <= '0;
                        slot_tnew[gi]  <= '0;
                        slot_cp0wr[gi] <= 1'b0;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        slot_valid[gi] <= 1'b0;
                        slot_wb[gi]    <= '0;
                        slot_rs[gi]    <= '0;
                        slot_rt[gi]    <= '0;
                        slot_tnew[gi]  <= '0;
                        slot_cp0wr[gi] <= 1'b0;
                    end else if (int_req) begin
                        slot_valid[gi] <= 1'b0;
                        slot_wb[gi]    <= '0;
                        slot_rs[gi]    <= '0;
                        slot_rt[gi]    <= '0;
                        slot_tnew[gi]  <= '0;
                        slot_cp0wr[gi] <= 1'b0;
                    end else begin
                        slot_valid[gi] <= slot_valid[gi-1];
                        slot_wb[gi]    <= slot_wb[gi-1];
                        slot_rs[gi]    <= slot_rs[gi-1];
                        slot_rt[gi]    <= slot_rt[gi-1];
                        slot_tnew[gi]  <= (slot_tnew[gi-1] == '0) ? '0
                                          : slot_tnew[gi-1] - TW'(1);
                        slot_cp0wr[gi] <= slot_cp0wr[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching slot overrides older ones.
    always_comb begin
        d_rs_idx  = '0;
        d_rs_tnew = '0;
        d_rt_idx  = '0;
        d_rt_tnew = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (slot_live[k] && (slot_wb[k] == d_rs)) begin
                d_rs_idx  = SW'(k);
                d_rs_tnew = slot_tnew[k];
            end
            if (slot_live[k] && (slot_wb[k] == d_rt)) begin
                d_rt_idx  = SW'(k);
                d_rt_tnew = slot_tnew[k];
            end
        end
    end

    generate
        if (STAGES >= 2) begin : g_e_search
            always_comb begin
                e_rs_idx  = '0;
                e_rs_tnew = '0;
                e_rt_idx  = '0;
                e_rt_tnew = '0;
                for (int k = STAGES; k >= 2; k--) begin
                    if (slot_live[k] && (slot_wb[k] == slot_rs[1])) begin
                        e_rs_idx  = SW'(k);
                        e_rs_tnew = slot_tnew[k];
                    end
                    if (slot_live[k] && (slot_wb[k] == slot_rt[1])) begin
                        e_rt_idx  = SW'(k);
                        e_rt_tnew = slot_tnew[k];
                    end
                end
            end
        end else begin : g_e_none
            assign e_rs_idx  = '0;
            assign e_rs_tnew = '0;
            assign e_rt_idx  = '0;
            assign e_rt_tnew = '0;
        end

        if (STAGES >= 3) begin : g_m_search
            always_comb begin
                m_rt_idx  = '0;
                m_rt_tnew = '0;
                for (int k = STAGES; k >= 3; k--) begin
                    if (slot_live[k] && (slot_wb[k] == slot_rt[2])) begin
                        m_rt_idx  = SW'(k);
                        m_rt_tnew = slot_tnew[k];
                    end
                end
            end
        end else begin : g_m_none
            assign m_rt_idx  = '0;
            assign m_rt_tnew = '0;
        end
    endgenerate

    // A producer that is not yet ready but will be by tuse needs neither stall
    // nor D forwarding: E/M forwarding picks the value up downstream.
    assign rs_block = d_valid && d_rs_used && (d_rs_idx != '0) && (d_rs_tnew > d_rs_tuse);
    assign rt_block = d_valid && d_rt_used && (d_rt_idx != '0) && (d_rt_tnew > d_rt_tuse);
    assign fwd_d_rs = (d_valid && d_rs_used && (d_rs_idx != '0) && (d_rs_tnew == '0))
                      ? d_rs_idx : '0;
    assign fwd_d_rt = (d_valid && d_rt_used && (d_rt_idx != '0) && (d_rt_tnew == '0))
                      ? d_rt_idx : '0;

    assign fwd_e_rs = (slot_valid[1] && (e_rs_idx != '0) && (e_rs_tnew == '0)) ? e_rs_idx : '0;
    assign fwd_e_rt = (slot_valid[1] && (e_rt_idx != '0) && (e_rt_tnew == '0)) ? e_rt_idx : '0;
    generate
        if (STAGES >= 2) begin : g_m_fwd
            assign fwd_m_rt = (slot_valid[2] && (m_rt_idx != '0) && (m_rt_tnew == '0))
                              ? m_rt_idx : '0;
        end else begin : g_m_fwd_none
            assign fwd_m_rt = '0;
        end
    endgenerate

    // MD counter keeps running across interrupts; only an accepted start reloads it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= '0;
        end else if (accept && d_md_start) begin
            md_cnt <= d_md_op ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CW'(1);
        end
    end

    assign md_busy    = (md_cnt != '0);
    assign md_block   = d_valid && d_md_use && md_busy;
    assign stall_eret = d_valid && d_eret && (|slot_cp0_pend);
    assign stall      = rs_block || rt_block || stall_eret || md_block;
    assign accept     = d_valid && !stall && !int_req;

    assign flush_d  = int_req || (d_eret && d_valid && !stall);
    assign flush_e  = stall || int_req;
    assign flush_mw = int_req;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: an age-based in-flight instruction model
// is compared every cycle, plus literal expectations for the key scenarios.
module tb_hazard_scoreboard;
    localparam int STAGES   = 3;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b1;
    logic       d_valid    = 1'b0;
    logic [4:0] d_rs       = '0;
    logic [4:0] d_rt       = '0;
    logic       d_rs_used  = 1'b0;
    logic       d_rt_used  = 1'b0;
    logic [1:0] d_rs_tuse  = '0;
    logic [1:0] d_rt_tuse  = '0;
    logic [4:0] d_wb       = '0;
    logic [1:0] d_tnew     = '0;
    logic       d_cp0wr    = 1'b0;
    logic       d_eret     = 1'b0;
    logic       d_md_start = 1'b0;
    logic       d_md_op    = 1'b0;
    logic       d_md_use   = 1'b0;
    logic       int_req    = 1'b0;

    logic       stall, stall_eret, md_busy, flush_d, flush_e, flush_mw;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt), .d_rs_used(d_rs_used), .d_rt_used(d_rt_used),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_wb(d_wb), .d_tnew(d_tnew),
        .d_cp0wr(d_cp0wr), .d_eret(d_eret), .d_md_start(d_md_start), .d_md_op(d_md_op),
        .d_md_use(d_md_use), .int_req(int_req), .stall(stall), .stall_eret(stall_eret),
        .md_busy(md_busy), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs),
        .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt), .flush_d(flush_d), .flush_e(flush_e),
        .flush_mw(flush_mw)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0] wb;
        logic [4:0] rs;
        logic [4:0] rt;
        int         tnew0;
        int         age;   // cycles since entering E; slot index = age + 1
        bit         cp0;
    } rec_t;

    typedef struct packed {
        logic       stall, stall_eret, md_busy;
        logic [1:0] fdrs, fdrt, fers, fert, fmrt;
        logic       fd, fe, fmw;
    } exp_t;

    rec_t inflight[$];
    int   cyc      = 0;
    int   md_ready = 0;   // md busy while cyc < md_ready

    function automatic int youngest(input logic [4:0] r, input int min_age);
        int best = -1;
        for (int i = 0; i < inflight.size(); i++) begin
            if (inflight[i].age >= min_age && inflight[i].wb != 5'd0 && inflight[i].wb == r &&
                (best < 0 || inflight[i].age < inflight[best].age))
                best = i;
        end
        return best;
    endfunction

    function automatic int remaining(input int i);
        int t = inflight[i].tnew0 - inflight[i].age;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int at_age(input int a);
        int idx = -1;
        for (int i = 0; i < inflight.size(); i++)
            if (inflight[i].age == a) idx = i;
        return idx;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        int   b, c;
        bit   blk, cp0_any;
        e = '0;
        blk = 0;
        cp0_any = 0;
        if (d_valid && d_rs_used) begin
            b = youngest(d_rs, 0);
            if (b >= 0) begin
                if (remaining(b) > int'(d_rs_tuse)) blk = 1;
                else if (remaining(b) == 0) e.fdrs = 2'(inflight[b].age + 1);
            end
        end
        if (d_valid && d_rt_used) begin
            b = youngest(d_rt, 0);
            if (b >= 0) begin
                if (remaining(b) > int'(d_rt_tuse)) blk = 1;
                else if (remaining(b) == 0) e.fdrt = 2'(inflight[b].age + 1);
            end
        end
        c = at_age(0);
        if (c >= 0) begin
            b = youngest(inflight[c].rs, 1);
            if (b >= 0 && remaining(b) == 0) e.fers = 2'(inflight[b].age + 1);
            b = youngest(inflight[c].rt, 1);
            if (b >= 0 && remaining(b) == 0) e.fert = 2'(inflight[b].age + 1);
        end
        c = at_age(1);
        if (c >= 0) begin
            b = youngest(inflight[c].rt, 2);
            if (b >= 0 && remaining(b) == 0) e.fmrt = 2'(inflight[b].age + 1);
        end
        foreach (inflight[i]) if (inflight[i].cp0) cp0_any = 1;
        e.stall_eret = d_valid && d_eret && cp0_any;
        e.md_busy    = (cyc < md_ready);
        e.stall      = blk || e.stall_eret || (d_valid && d_md_use && e.md_busy);
        e.fd         = int_req || (d_eret && d_valid && !e.stall);
        e.fe         = e.stall || int_req;
        e.fmw        = int_req;
        return e;
    endfunction

    task automatic model_step();
        exp_t e;
        rec_t keep[$];
        rec_t r;
        e = model_outputs();
        if (int_req) begin
            inflight.delete();
        end else begin
            foreach (inflight[i]) begin
                r = inflight[i];
                r.age++;
                if (r.age < STAGES) keep.push_back(r);
            end
            inflight = keep;
            if (d_valid && !e.stall) begin
                r.wb = d_wb; r.rs = d_rs; r.rt = d_rt;
                r.tnew0 = int'(d_tnew); r.age = 0; r.cp0 = d_cp0wr;
                inflight.push_back(r);
                if (d_md_start) md_ready = cyc + 1 + (d_md_op ? DIV_CYC : MULT_CYC);
            end
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            inflight.delete();
            md_ready = 0;
        end else begin
            model_step();
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0b, want %0b", name, $time, act, exp);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    initial forever begin
        exp_t ce;
        @(negedge clk);
        ce = model_outputs();
        chk1("stall", stall, ce.stall);
        chk1("stall_eret", stall_eret, ce.stall_eret);
        chk1("md_busy", md_busy, ce.md_busy);
        chk2("fwd_d_rs", fwd_d_rs, ce.fdrs);
        chk2("fwd_d_rt", fwd_d_rt, ce.fdrt);
        chk2("fwd_e_rs", fwd_e_rs, ce.fers);
        chk2("fwd_e_rt", fwd_e_rt, ce.fert);
        chk2("fwd_m_rt", fwd_m_rt, ce.fmrt);
        chk1("flush_d", flush_d, ce.fd);
        chk1("flush_e", flush_e, ce.fe);
        chk1("flush_mw", flush_mw, ce.fmw);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] rs_t,
                         input logic [4:0] rt, input logic [1:0] rt_t,
                         input logic [4:0] wb, input logic [1:0] tn, input string label);
        d_valid = v; d_rs = rs; d_rs_used = (rs != 5'd0); d_rs_tuse = rs_t;
        d_rt = rt; d_rt_used = (rt != 5'd0); d_rt_tuse = rt_t;
        d_wb = wb; d_tnew = tn; d_cp0wr = 1'b0; d_eret = 1'b0;
        d_md_start = 1'b0; d_md_op = 1'b0; d_md_use = 1'b0; int_req = 1'b0;
        $display("[%0t] D <= %s", $time, label);
    endtask

    task automatic drain();
        drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, "nop");
        repeat (STAGES + 1) tick();
    endtask

    initial begin
        int n;
        #2 reset_n = 1'b0;
        #1;
        chk1("reset_stall", stall, 1'b0);
        chk1("reset_md_busy", md_busy, 1'b0);
        chk2("reset_fwd_d_rs", fwd_d_rs, 2'd0);
        chk1("reset_flush_e", flush_e, 1'b0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // ALU back-to-back
        tick(); drive(1'b1, 5'd1, 2'd0, 5'd2, 2'd0, 5'd3, 2'd0, "addu $3,$1,$2");
        tick(); drive(1'b1, 5'd3, 2'd0, 5'd4, 2'd0, 5'd0, 2'd0, "beq $3,$4");
        #2;
        chk1("alu_stall", stall, 1'b0);
        chk2("alu_fwd_d_rs", fwd_d_rs, 2'd1);
        chk2("alu_fwd_d_rt", fwd_d_rt, 2'd0);
        tick(); drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, "nop");
        #2 chk2("alu_fwd_e_rs", fwd_e_rs, 2'd2);
        drain();

        // load-use, tuse 1
        tick(); drive(1'b1, 5'd1, 2'd0, 5'd0, 2'd0, 5'd5, 2'd2, "lw $5");
        tick(); drive(1'b1, 5'd5, 2'd1, 5'd7, 2'd1, 5'd6, 2'd0, "addu $6,$5,$7");
        #2;
        chk1("lu_stall_1", stall, 1'b1);
        chk1("lu_flush_e", flush_e, 1'b1);
        tick();
        #2;
        chk1("lu_stall_2", stall, 1'b0);
        chk2("lu_fwd_d_rs", fwd_d_rs, 2'd0);
        tick(); drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, "nop");
        #2 chk2("lu_fwd_e_rs", fwd_e_rs, 2'd3);
        drain();

        // store data through E then M forwarding
        tick(); drive(1'b1, 5'd1, 2'd0, 5'd0, 2'd0, 5'd9, 2'd1, "producer $9 tnew1");
        tick(); drive(1'b1, 5'd0, 2'd0, 5'd9, 2'd2, 5'd0, 2'd0, "sw $9");
        #2;
        chk1("sw_stall", stall, 1'b0);
        chk2("sw_fwd_d_rt", fwd_d_rt, 2'd0);
        tick(); drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, "nop");
        #2 chk2("sw_fwd_e_rt", fwd_e_rt, 2'd2);
        tick();
        #2 chk2("sw_fwd_m_rt", fwd_m_rt, 2'd3);
        drain();

        // divide then mflo
        tick(); drive(1'b1, 5'd1, 2'd0, 5'd2, 2'd0, 5'd0, 2'd0, "div $1,$2");
        d_md_start = 1'b1; d_md_op = 1'b1; d_md_use = 1'b1;
        #2 chk1("div_accept", stall, 1'b0);
        tick(); drive(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd10, 2'd0, "mflo $10");
        d_md_use = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (!stall) break;
            n++;
            tick();
        end
        chki("div_stall_cycles", n, 10);
        chk1("div_busy_released", md_busy, 1'b0);
        tick(); drive(1'b1, 5'd3, 2'd0, 5'd4, 2'd0, 5'd0, 2'd0, "mult $3,$4");
        d_md_start = 1'b1; d_md_use = 1'b1;
        tick(); drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, "nop");
        #2 chk1("mult_busy_first", md_busy, 1'b1);
        repeat (4) tick();
        #2 chk1("mult_busy_last", md_busy, 1'b1);
        tick();
        #2 chk1("mult_busy_done", md_busy, 1'b0);
        drain();

        // mtc0 then eret
        tick(); drive(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, "mtc0");
        d_cp0wr = 1'b1;
        tick(); drive(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, "eret");
        d_eret = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (!stall_eret) break;
            n++;
            tick();
        end
        chki("eret_stall_cycles", n, 3);
        chk1("eret_flush_d", flush_d, 1'b1);
        chk1("eret_stall_clear", stall, 1'b0);
        tick(); drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, "nop");
        #2 chk1("eret_flush_d_once", flush_d, 1'b0);
        drain();

        // interrupt during a load-use stall
        tick(); drive(1'b1, 5'd1, 2'd0, 5'd0, 2'd0, 5'd11, 2'd2, "lw $11");
        tick(); drive(1'b1, 5'd11, 2'd0, 5'd0, 2'd0, 5'd12, 2'd0, "beq $11 + int_req");
        int_req = 1'b1;
        #2;
        chk1("int_stall", stall, 1'b1);
        chk1("int_flush_d", flush_d, 1'b1);
        chk1("int_flush_e", flush_e, 1'b1);
        chk1("int_flush_mw", flush_mw, 1'b1);
        tick(); int_req = 1'b0;
        #2;
        chk1("post_int_stall", stall, 1'b0);
        chk2("post_int_fwd_d_rs", fwd_d_rs, 2'd0);
        chk2("post_int_fwd_e_rs", fwd_e_rs, 2'd0);
        chk1("post_int_flush_e", flush_e, 1'b0);
        drain();

        // reset mid-divide with a pending load
        tick(); drive(1'b1, 5'd1, 2'd0, 5'd2, 2'd0, 5'd0, 2'd0, "div $1,$2");
        d_md_start = 1'b1; d_md_op = 1'b1; d_md_use = 1'b1;
        tick(); drive(1'b1, 5'd1, 2'd0, 5'd0, 2'd0, 5'd12, 2'd2, "lw $12");
        #2 chk1("rst_pre_busy", md_busy, 1'b1);
        tick(); drive(1'b1, 5'd12, 2'd0, 5'd0, 2'd0, 5'd13, 2'd0, "addu $13,$12");
        #2 chk1("rst_pre_stall", stall, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("rst_async_stall", stall, 1'b0);
        chk1("rst_async_md_busy", md_busy, 1'b0);
        chk1("rst_async_flush_e", flush_e, 1'b0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick(); drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, "nop");
        #2 chk1("rst_release_md_busy", md_busy, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
